// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: constants, FSM encodings
// and the instruction/PC pair carried through the output and skid registers.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_word_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_unit_skid.sv
// One-entry instruction/PC buffer that catches a response arriving while the
// decoder is stalled. Flush wins over load, load wins over unload.
module fetch_skid
    import fetch_unit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_flush,
    input  fetch_word_t i_word,
    output logic        o_valid,
    output fetch_word_t o_word
);

    logic        r_valid;
    fetch_word_t r_word;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack memory FSM, registered decode
// output with a one-entry skid, and redirect with in-flight response discard.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    output logic [1:0]  o_state
);

    logic [1:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;

    logic        w_req;
    logic        w_ack;
    logic        w_consume;
    logic        w_free;
    logic [31:0] w_redirect_target;
    logic        w_skid_load;
    logic        w_skid_unload;
    logic        w_skid_valid;
    fetch_word_t w_skid_in;
    fetch_word_t w_skid_out;

    // Memory handshake: address is the abandoned one while draining, so it
    // never changes under an outstanding request.
    assign w_req       = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign o_imem_req  = w_req;
    assign o_imem_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_fetch_pc;
    assign w_ack       = i_imem_ack && w_req;

    assign w_consume         = r_instr_valid && !i_stall;
    assign w_free            = !r_instr_valid || w_consume;
    assign w_redirect_target = i_redirect_pc & WORD_MASK;

    assign w_skid_in     = '{pc: r_fetch_pc, instr: i_imem_rdata};
    assign w_skid_load   = !i_redirect && (r_state == ST_FETCH) && w_ack && !w_free;
    assign w_skid_unload = !i_redirect && (r_state == ST_HOLD) && w_consume && w_skid_valid;

    fetch_skid u_skid (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (i_redirect),
        .i_word   (w_skid_in),
        .o_valid  (w_skid_valid),
        .o_word   (w_skid_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_drain_addr  <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
        end else if (i_redirect) begin
            // Flush the output even if it is consumed this cycle.
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_fetch_pc    <= w_redirect_target;
            case (r_state)
                ST_FETCH: begin
                    if (w_ack) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state      <= ST_DRAIN;
                        r_drain_addr <= r_fetch_pc;
                    end
                end
                ST_DRAIN: r_state <= ST_DRAIN;
                default:  r_state <= ST_FETCH;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_ack && w_free) begin
                        r_instr       <= i_imem_rdata;
                        r_instr_pc    <= r_fetch_pc;
                        r_instr_valid <= 1'b1;
                        r_fetch_pc    <= next_pc(r_fetch_pc);
                    end else if (w_ack) begin
                        r_fetch_pc <= next_pc(r_fetch_pc);
                        r_state    <= ST_HOLD;
                    end else if (w_consume) begin
                        r_instr_valid <= 1'b0;
                        r_instr       <= NOP_INSTR;
                    end
                end
                ST_HOLD: begin
                    if (w_consume && w_skid_valid) begin
                        r_instr    <= w_skid_out.instr;
                        r_instr_pc <= w_skid_out.pc;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // Response belongs to the pre-redirect stream; drop it.
                    if (w_ack) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_state       = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory with variable
// ack latency, a scoreboard of expected {pc, instr} pairs, and step checks.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] XORPAT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    int lat = 0;
    int cnt = 0;
    bit mem_en = 1'b1;
    bit force_ack = 1'b0;

    logic [63:0] exp_q[$];

    fetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, pc ^ XORPAT});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers after 'lat' wait cycles with addr ^ XORPAT.
    always @(posedge clk) begin
        #2;
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (mem_en && imem_req) begin
            if (cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ XORPAT;
                cnt        = 0;
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            cnt      = 0;
        end
    end

    // Scoreboard: every consumed instruction must be the next expected one.
    always @(negedge clk) begin
        if (!rst && instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pc", instr_pc, 32'hXXXX_XXXX);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e[63:32]);
                check("sb_instr", instr, e[31:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
        push_exp(32'h0000_0100);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_state", {30'b0, state}, {30'b0, ST_IDLE});
        rst = 1'b0;

        tick();
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        check("first_valid", {31'b0, instr_valid}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_valid", {31'b0, instr_valid}, 32'd1);
            check("stream_pc", instr_pc, 32'(i * 4));
        end
        stall = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_state", {30'b0, state}, {30'b0, ST_HOLD});
            check("hold_req", {31'b0, imem_req}, 32'd0);
            check("hold_pc", instr_pc, 32'd12);
        end
        stall = 1'b0;

        tick();
        check("skid_pc", instr_pc, 32'd16);
        check("skid_valid", {31'b0, instr_valid}, 32'd1);
        tick();
        check("resume_pc", instr_pc, 32'd20);
        lat = 3;

        tick();
        check("wait_valid", {31'b0, instr_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;

        tick();
        redirect = 1'b0;
        check("drain_state", {30'b0, state}, {30'b0, ST_DRAIN});
        check("drain_addr", imem_addr, 32'd24);
        check("drain_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        check("drain_valid2", {31'b0, instr_valid}, 32'd0);
        tick();
        check("post_drain_addr", imem_addr, 32'h0000_0100);
        check("post_drain_state", {30'b0, state}, {30'b0, ST_FETCH});
        check("post_drain_valid", {31'b0, instr_valid}, 32'd0);
        lat = 0;

        tick();
        check("redir_pc", instr_pc, 32'h0000_0100);
        check("redir_instr", instr, 32'h0000_0100 ^ XORPAT);
        tick();
        check("pre_stall_pc", instr_pc, 32'h0000_0104);
        stall = 1'b1;

        tick();
        check("skid_full_state", {30'b0, state}, {30'b0, ST_HOLD});
        check("skid_full_pc", instr_pc, 32'h0000_0104);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;

        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("flush_valid", {31'b0, instr_valid}, 32'd0);
        check("flush_instr", instr, NOP);
        check("flush_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);
        tick();
        check("wrap_next_pc", instr_pc, 32'h0);
        lat = 5;

        tick();
        check("pending_valid", {31'b0, instr_valid}, 32'd0);
        check("pending_req", {31'b0, imem_req}, 32'd1);
        rst = 1'b1;

        tick();
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        check("mid_rst_state", {30'b0, state}, {30'b0, ST_IDLE});
        check("mid_rst_pc", instr_pc, 32'h0);
        force_ack = 1'b1;
        tick();
        check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        push_exp(32'h0);
        push_exp(32'h4);
        rst = 1'b0;

        tick();
        check("post_rst_req", {31'b0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_valid", {31'b0, instr_valid}, 32'd0);
        force_ack = 1'b0;
        lat       = 0;

        tick();
        check("post_rst_out_pc", instr_pc, 32'h0);
        tick();
        check("post_rst_next_pc", instr_pc, 32'h4);
        mem_en = 1'b0;

        repeat (3) tick();
        check("idle_valid", {31'b0, instr_valid}, 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
